rate_shifter: RTL and testbench
===============================

Name: rate_shifter

Overview:
- Parametrised successor to the button-driven one-hot rate shifter. Holds a WIDTH-bit one-hot rate selector that moves toward the MSB on shift_left and toward the LSB on shift_right.
- Adds edge-detected presses (one shift per press), hold-to-auto-repeat, a selectable saturate/wrap mode, a configurable reset position, position and limit flags, and a change strobe.
- Sits between debounced button inputs and the blink/rate generator.

Parameters:
- WIDTH, 4: number of one-hot positions; must be at least 2.
- WRAP, 0: 0 = saturate at the ends; 1 = wrap around.
- RESET_POS, 0: one-hot index loaded at reset; must be in 0..WIDTH-1.
- REPEAT_DELAY, 8: cycles a button must be held after the press shift before the first auto-repeat shift; 0 disables auto-repeat.
- REPEAT_PERIOD, 4: cycles between later auto-repeat shifts; must be at least 1.
- PW, $clog2(WIDTH): width of pos (derived, not to be overridden).

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- shift_left  in  1  synchronous, debounced request; moves toward the MSB.
- shift_right  in  1  synchronous, debounced request; moves toward the LSB.
- out  out  WIDTH  registered one-hot rate selector.
- pos  out  PW  registered index of the set bit in out.
- at_min  out  1  registered; high when pos == 0.
- at_max  out  1  registered; high when pos == WIDTH-1.
- changed  out  1  registered one-cycle strobe, high in the first cycle a new out value is visible.

Behaviour:
- Reset (rst low, asynchronous):
  - out = 1<<RESET_POS, pos = RESET_POS, at_min/at_max consistent with RESET_POS, changed = 0.
  - FSM = IDLE, repeat counter = 0.
  - Previous-input registers = 0, so a button still held when rst deasserts counts as a new press.
- Edge detect: press_l = shift_left & ~prev_l; press_r likewise. The prev registers update every cycle.
- Shift operation (one step):
  - Left: pos+1. At pos == WIDTH-1, pos stays if WRAP=0, or becomes 0 if WRAP=1.
  - Right: pos-1. At pos == 0, pos stays if WRAP=0, or becomes WIDTH-1 if WRAP=1.
  - out is always exactly one-hot and equal to 1<<pos.
  - changed pulses only if pos actually changes. A saturated shift produces no strobe.
- Latency: a press sampled at edge N updates out, pos, flags and changed at edge N (visible in cycle N+1). changed falls at edge N+1 unless another shift occurs.
- FSM states: IDLE, HOLD_DELAY, HOLD_REPEAT, BLOCKED.
- IDLE:
  - Both inputs high → BLOCKED, no shift.
  - press on exactly one input with the other low → perform the shift, clear the counter, go to HOLD_DELAY (go to IDLE instead if REPEAT_DELAY = 0).
- HOLD_DELAY:
  - Active button released → IDLE.
  - Other button asserted → BLOCKED.
  - Otherwise the counter increments. When the count reaches REPEAT_DELAY (the shift lands REPEAT_DELAY cycles after the press shift), perform a repeat shift, clear the counter, go to HOLD_REPEAT.
- HOLD_REPEAT: same release and block rules as HOLD_DELAY. Perform a shift every REPEAT_PERIOD cycles while the button is held alone.
- BLOCKED: no shifts. Go to IDLE only when both inputs are low. A button that stays high never re-triggers.
- Saturation does not stop auto-repeat sequencing; shifts at the limit are no-ops with no strobe.
- Counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). It must never wrap before its compare point.
- Reset mid-hold: returns to the reset state immediately. After release, a held button is treated as a fresh press on the first clock edge.

Test Plan:
- WIDTH=4, WRAP=0, RESET_POS=0: release reset, then pulse shift_left for 1 cycle three times → out 0010, 0100, 1000, with changed high one cycle each. A fourth pulse → out stays 1000, changed stays 0, at_max=1.
- WIDTH=4, WRAP=1, at out=1000: one shift_left pulse → out=0001, pos=0, at_min=1, changed=1. Then one shift_right pulse → out=1000.
- REPEAT_DELAY=8, REPEAT_PERIOD=4, WIDTH=8, RESET_POS=0: hold shift_left for 20 cycles from press cycle 0 → shifts at cycles 0, 8, 12, 16; out=00010000 afterward.
- Hold shift_left, assert shift_right on cycle 3 while left is still held, release both on cycle 10 → exactly one shift (at cycle 0), no further changed pulses, FSM returns to IDLE.
- Hold shift_right through rst assertion (RESET_POS=2, WIDTH=4), then deassert rst → out=0100 during reset; on the first clock edge after deassertion, out=0010 and changed=1.
- REPEAT_DELAY=0: hold shift_left for 30 cycles → exactly one shift.

Source files
------------

// File: rtl/rate_shifter.sv
// One-hot rate selector driven by debounced left/right buttons, with press edge
// detection, hold-to-auto-repeat, saturate or wrap at the ends, and a change strobe.
module rate_shifter #(
  parameter int WIDTH         = 4,
  parameter int WRAP          = 0,
  parameter int RESET_POS     = 0,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int PW            = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_left,
  input  logic             shift_right,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    pos,
  output logic             at_min,
  output logic             at_max,
  output logic             changed
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    DELAY_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0]    PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [PW-1:0]    POS_MAX     = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    POS_RESET   = PW'(RESET_POS);
  localparam logic [WIDTH-1:0] OUT_RESET   = WIDTH'(1) << RESET_POS;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2,
    BLOCKED     = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic           dir_reg, dir_next;      // 1 = left button owns the current hold
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           prev_l_reg, prev_r_reg;
  logic [PW-1:0]  pos_reg, pos_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic           at_min_reg, at_max_reg, changed_reg;

  logic press_l, press_r;
  logic active_held, other_held;
  logic do_shift, shift_is_left;

  assign press_l     = shift_left  & ~prev_l_reg;
  assign press_r     = shift_right & ~prev_r_reg;
  assign active_held = dir_reg ? shift_left  : shift_right;
  assign other_held  = dir_reg ? shift_right : shift_left;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      dir_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        if (shift_left && shift_right) begin
          state_next = BLOCKED;
        end else if (press_l || press_r) begin
          dir_next   = press_l;
          state_next = (REPEAT_DELAY == 0) ? IDLE : HOLD_DELAY;
        end
      end
      HOLD_DELAY: begin
        if (!active_held)               state_next = IDLE;
        else if (other_held)            state_next = BLOCKED;
        else if (cnt_reg == DELAY_LAST) state_next = HOLD_REPEAT;
      end
      HOLD_REPEAT: begin
        if (!active_held)    state_next = IDLE;
        else if (other_held) state_next = BLOCKED;
      end
      BLOCKED: begin
        if (!shift_left && !shift_right) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: shift requests and repeat counter
  always_comb begin
    do_shift      = 1'b0;
    shift_is_left = dir_reg;
    cnt_next      = '0;
    case (state_reg)
      IDLE: begin
        if (!(shift_left && shift_right) && (press_l || press_r)) begin
          do_shift      = 1'b1;
          shift_is_left = press_l;
        end
      end
      HOLD_DELAY: begin
        if (active_held && !other_held) begin
          if (cnt_reg == DELAY_LAST) do_shift = 1'b1;
          else                       cnt_next = cnt_reg + CW'(1);
        end
      end
      HOLD_REPEAT: begin
        if (active_held && !other_held) begin
          if (cnt_reg == PERIOD_LAST) do_shift = 1'b1;
          else                        cnt_next = cnt_reg + CW'(1);
        end
      end
      default: cnt_next = '0;
    endcase
  end

  // Position update; a shift into a saturated end leaves pos unchanged
  always_comb begin
    pos_next = pos_reg;
    if (do_shift) begin
      if (shift_is_left) begin
        if (pos_reg != POS_MAX) pos_next = pos_reg + PW'(1);
        else if (WRAP != 0)     pos_next = '0;
      end else begin
        if (pos_reg != '0)      pos_next = pos_reg - PW'(1);
        else if (WRAP != 0)     pos_next = POS_MAX;
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
    assign out_next[gi] = (pos_next == PW'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_l_reg  <= 1'b0;
      prev_r_reg  <= 1'b0;
      pos_reg     <= POS_RESET;
      out_reg     <= OUT_RESET;
      at_min_reg  <= (POS_RESET == '0);
      at_max_reg  <= (POS_RESET == POS_MAX);
      changed_reg <= 1'b0;
    end else begin
      prev_l_reg  <= shift_left;
      prev_r_reg  <= shift_right;
      pos_reg     <= pos_next;
      out_reg     <= out_next;
      at_min_reg  <= (pos_next == '0);
      at_max_reg  <= (pos_next == POS_MAX);
      changed_reg <= (pos_next != pos_reg);
    end
  end

  assign out     = out_reg;
  assign pos     = pos_reg;
  assign at_min  = at_min_reg;
  assign at_max  = at_max_reg;
  assign changed = changed_reg;

endmodule

// File: tb/tb_rate_shifter.sv
// Bench for rate_shifter: three parameterisations share clk/rst; per-cycle vectors
// go through a scoreboard queue and are compared one cycle after being driven.
module tb_rate_shifter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // d0: W4 saturate, d1: W4 wrap reset-pos 2 no repeat, d2: W8 saturate with repeat
  logic       l0 = 1'b0, r0 = 1'b0, l1 = 1'b0, r1 = 1'b0, l2 = 1'b0, r2 = 1'b0;
  logic [3:0] out0, out1;
  logic [7:0] out2;
  logic [1:0] pos0, pos1;
  logic [2:0] pos2;
  logic       mn0, mx0, ch0, mn1, mx1, ch1, mn2, mx2, ch2;

  rate_shifter #(.WIDTH(4), .WRAP(0), .RESET_POS(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) u_d0 (
    .clk(clk), .rst(rst), .shift_left(l0), .shift_right(r0),
    .out(out0), .pos(pos0), .at_min(mn0), .at_max(mx0), .changed(ch0));

  rate_shifter #(.WIDTH(4), .WRAP(1), .RESET_POS(2), .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) u_d1 (
    .clk(clk), .rst(rst), .shift_left(l1), .shift_right(r1),
    .out(out1), .pos(pos1), .at_min(mn1), .at_max(mx1), .changed(ch1));

  rate_shifter #(.WIDTH(8), .WRAP(0), .RESET_POS(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) u_d2 (
    .clk(clk), .rst(rst), .shift_left(l2), .shift_right(r2),
    .out(out2), .pos(pos2), .at_min(mn2), .at_max(mx2), .changed(ch2));

  typedef struct {
    int         dut;
    logic       l;
    logic       r;
    logic [7:0] out;
    logic [2:0] pos;
    logic       chg;
    logic       mn;
    logic       mx;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(int d, int l, int r, int o, int p, int c, int mn, int mx);
    vec_t v;
    v.dut = d;
    v.l   = (l != 0);
    v.r   = (r != 0);
    v.out = 8'(o);
    v.pos = 3'(p);
    v.chg = (c != 0);
    v.mn  = (mn != 0);
    v.mx  = (mx != 0);
    return v;
  endfunction

  task automatic check(string name, vec_t e);
    logic [7:0] ao;
    logic [2:0] ap;
    logic       ac, amn, amx;
    case (e.dut)
      0:       begin ao = {4'b0, out0}; ap = {1'b0, pos0}; ac = ch0; amn = mn0; amx = mx0; end
      1:       begin ao = {4'b0, out1}; ap = {1'b0, pos1}; ac = ch1; amn = mn1; amx = mx1; end
      default: begin ao = out2;         ap = pos2;         ac = ch2; amn = mn2; amx = mx2; end
    endcase
    n_checks++;
    if ({ao, ap, ac, amn, amx} === {e.out, e.pos, e.chg, e.mn, e.mx}) begin
      n_pass++;
    end else begin
      $display("FAIL %s d%0d: got out=%b pos=%0d chg=%b min=%b max=%b, expected out=%b pos=%0d chg=%b min=%b max=%b",
               name, e.dut, ao, ap, ac, amn, amx, e.out, e.pos, e.chg, e.mn, e.mx);
    end
  endtask

  task automatic apply(vec_t v, string name);
    @(negedge clk);
    case (v.dut)
      0:       begin l0 = v.l; r0 = v.r; end
      1:       begin l1 = v.l; r1 = v.r; end
      default: begin l2 = v.l; r2 = v.r; end
    endcase
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(name, sb.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Saturating single pulses on d0, then one right pulse
    tbl.push_back(mk(0, 1, 0, 'h02, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h02, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h04, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h04, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h08, 3, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 'h08, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 'h08, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 'h08, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 'h04, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h04, 2, 0, 0, 0));
    // Wrapping pulses on d1 (starts at pos 2)
    tbl.push_back(mk(1, 1, 0, 'h08, 3, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 'h08, 3, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 'h01, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 'h01, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 'h08, 3, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 'h08, 3, 0, 0, 1));

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_d0", mk(0, 0, 0, 'h01, 0, 0, 1, 0));
    check("reset_d1", mk(1, 0, 0, 'h04, 2, 0, 0, 0));
    check("reset_d2", mk(2, 0, 0, 'h01, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // d0 at pos 2: hold right, left joins at cycle 3, both released at cycle 10
    for (int c = 0; c < 12; c++)
      apply(mk(0, (c >= 3 && c < 10) ? 1 : 0, (c < 10) ? 1 : 0, 'h02, 1, (c == 0) ? 1 : 0, 0, 0),
            $sformatf("block_c%0d", c));
    apply(mk(0, 1, 0, 'h04, 2, 1, 0, 0), "block_repress");
    apply(mk(0, 0, 0, 'h04, 2, 0, 0, 0), "block_release");

    // d2: hold left 20 cycles; shifts expected at 0, 8, 12, 16
    for (int k = 0; k < 20; k++) begin
      int p;
      int c;
      p = 1 + ((k >= 8) ? 1 + (k - 8) / 4 : 0);
      c = (k == 0 || (k >= 8 && (k - 8) % 4 == 0)) ? 1 : 0;
      apply(mk(2, 1, 0, 1 << p, p, c, 0, 0), $sformatf("repeat_k%0d", k));
    end
    apply(mk(2, 0, 0, 'h10, 4, 0, 0, 0), "repeat_release");

    // d1 (no auto-repeat) at pos 3: hold left 30 cycles gives one wrap shift only
    for (int k = 0; k < 30; k++)
      apply(mk(1, 1, 0, 'h01, 0, (k == 0) ? 1 : 0, 1, 0), $sformatf("norep_k%0d", k));
    apply(mk(1, 0, 0, 'h01, 0, 0, 1, 0), "norep_release");

    // d1: hold right across an asynchronous reset
    @(negedge clk);
    r1  = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_async", mk(1, 0, 0, 'h04, 2, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", mk(1, 0, 0, 'h04, 2, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_first_edge", mk(1, 0, 0, 'h02, 1, 1, 0, 0));
    @(posedge clk);
    #1;
    check("rst_still_held", mk(1, 0, 0, 'h02, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 'h02, 1, 0, 0, 0), "rst_release");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
